// File: rtl/dcache_wb_pkg.sv
// Shared types and address-field constants for the direct-mapped write-back data cache.
package dcache_wb_pkg;
    localparam int INDEX_BITS     = 6;
    localparam int OFFSET_BITS    = 2;
    localparam int TAG_BITS       = 32 - INDEX_BITS - OFFSET_BITS - 2;
    localparam int NUM_LINES      = 1 << INDEX_BITS;
    localparam int WORDS_PER_LINE = 1 << OFFSET_BITS;

    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = OFFSET_LSB + OFFSET_BITS;
    localparam int TAG_LSB    = INDEX_LSB + INDEX_BITS;

    typedef logic [TAG_BITS-1:0]                 tag_t;
    typedef logic [INDEX_BITS-1:0]               index_t;
    typedef logic [OFFSET_BITS-1:0]              offset_t;
    typedef logic [31:0]                         word_t;
    typedef logic [WORDS_PER_LINE-1:0][31:0]     line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        RESP = 2'd3
    } state_t;
endpackage

// File: rtl/dcache_wb_line_array.sv
// Line storage: valid/dirty/tag/data per line, combinational read, single write port
// shared by store hits and refill words (refill's last word also installs the tag).
module dcache_line_array
    import dcache_wb_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  index_t  rd_index,
    output logic    rd_valid,
    output logic    rd_dirty,
    output tag_t    rd_tag,
    output line_t   rd_line,
    input  logic    wr_en,
    input  index_t  wr_index,
    input  offset_t wr_offset,
    input  word_t   wr_data,
    input  logic    wr_dirty,
    input  logic    wr_fill_last,
    input  tag_t    wr_tag
);
    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    tag_t                 tag_q  [NUM_LINES];
    line_t                data_q [NUM_LINES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            if (wr_fill_last) begin
                valid_q[wr_index] <= 1'b1;
                dirty_q[wr_index] <= 1'b0;
            end else if (wr_dirty) begin
                dirty_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tags and data need no reset: valid gates every use of them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_index][wr_offset] <= wr_data;
            if (wr_fill_last)
                tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];
endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache; optional counters with DCACHE_STAT_EN.
// state | meaning
// IDLE  | serve hits combinationally, detect misses
// WB    | write dirty victim words 0..3 to RAM
// FILL  | read line words 0..3 from RAM
// RESP  | complete the stalled access as a hit
module dcache_wb
    import dcache_wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_ren,
    input  logic        cpu_wen,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_din,
    output logic [31:0] cpu_dout,
    output logic        cpu_stall,
    output logic        ram_cs,
    output logic        ram_ren,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_dout,
    input  logic [31:0] ram_din,
    input  logic        ram_ack
`ifdef DCACHE_STAT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    state_t  state_q, state_d;
    offset_t word_cnt_q, word_cnt_d;

    tag_t    cpu_tag;
    index_t  cpu_index;
    offset_t cpu_offset;
    logic    unused_addr_bits;

    logic    line_valid, line_dirty;
    tag_t    line_tag;
    line_t   line_data;

    logic    req, hit, store_now, fill_wr;
    logic    wr_en, wr_fill_last;
    offset_t wr_offset;
    word_t   wr_data;

    assign cpu_tag          = cpu_addr[TAG_LSB +: TAG_BITS];
    assign cpu_index        = cpu_addr[INDEX_LSB +: INDEX_BITS];
    assign cpu_offset       = cpu_addr[OFFSET_LSB +: OFFSET_BITS];
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign req = cpu_ren | cpu_wen;
    assign hit = line_valid && (line_tag == cpu_tag);

    dcache_line_array u_lines (
        .clk          (clk),
        .rst          (rst),
        .rd_index     (cpu_index),
        .rd_valid     (line_valid),
        .rd_dirty     (line_dirty),
        .rd_tag       (line_tag),
        .rd_line      (line_data),
        .wr_en        (wr_en),
        .wr_index     (cpu_index),
        .wr_offset    (wr_offset),
        .wr_data      (wr_data),
        .wr_dirty     (store_now),
        .wr_fill_last (wr_fill_last),
        .wr_tag       (cpu_tag)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        case (state_q)
            IDLE: if (req && !hit) state_d = (line_valid && line_dirty) ? WB : FILL;
            WB: if (ram_ack) begin
                word_cnt_d = word_cnt_q + 2'd1;
                if (&word_cnt_q) state_d = FILL;
            end
            FILL: if (ram_ack) begin
                word_cnt_d = word_cnt_q + 2'd1;
                if (&word_cnt_q) state_d = RESP;
            end
            RESP: state_d = IDLE;
        endcase
    end

    // Stores complete either as an IDLE hit or in RESP once the line is resident.
    assign store_now    = cpu_wen && ((state_q == IDLE && hit) || state_q == RESP);
    assign fill_wr      = (state_q == FILL) && ram_ack;
    assign wr_en        = store_now || fill_wr;
    assign wr_fill_last = fill_wr && (&word_cnt_q);
    assign wr_offset    = fill_wr ? word_cnt_q : cpu_offset;
    assign wr_data      = fill_wr ? ram_din : cpu_din;

    always_comb begin
        cpu_stall = 1'b0;
        cpu_dout  = '0;
        ram_ren   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_dout  = '0;
        case (state_q)
            IDLE: begin
                cpu_stall = rst && req && !hit;
                if (hit) cpu_dout = line_data[cpu_offset];
            end
            WB: begin
                cpu_stall = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = {2'b00, line_tag, cpu_index, word_cnt_q};
                ram_dout  = line_data[word_cnt_q];
            end
            FILL: begin
                cpu_stall = 1'b1;
                ram_ren   = 1'b1;
                ram_addr  = {2'b00, cpu_tag, cpu_index, word_cnt_q};
            end
            RESP: cpu_dout = line_data[cpu_offset];
        endcase
        ram_cs = ram_ren | ram_we;
    end

`ifdef DCACHE_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state_q == IDLE && req) begin
            if (hit && hit_cnt != '1)
                hit_cnt <= hit_cnt + 32'd1;
            if (!hit && miss_cnt != '1)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache.
- Sits between the core's load/store port (mem_ren/mem_wen/mem_addr/stall) and the word-wide data RAM, which uses a ren/we/cs/ack handshake.
- Hits complete combinationally with no stall.
- Misses stall the core while the FSM writes back a dirty victim line, if any, then refills the line word by word.

Parameters:
- INDEX_BITS, 6, log2 number of lines (64 lines).
- OFFSET_BITS, 2, log2 words per line (4 words, 16 B).
- TAG_BITS, 32-INDEX_BITS-OFFSET_BITS-2, tag width (22).

Ports:
- clk  in  1  main clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_ren  in  1  load request.
- cpu_wen  in  1  store request; wins over cpu_ren if both are high.
- cpu_addr  in  32  byte address; [1:0] ignored.
- cpu_din  in  32  store data.
- cpu_dout  out  32  load data; valid when not stalled.
- cpu_stall  out  1  core must hold its request while high.
- ram_cs  out  1  high whenever ram_ren or ram_we is high.
- ram_ren  out  1  word read request.
- ram_we  out  1  word write request.
- ram_addr  out  32  word address ({2'b0, byte_addr[31:2]}).
- ram_dout  out  32  write data to RAM.
- ram_din  in  32  read data from RAM; valid with ram_ack.
- ram_ack  in  1  one-cycle completion pulse.
- hit_cnt, miss_cnt  out  32 each  present only with DCACHE_STAT_EN.

Behaviour:
- Address split: tag = addr[31:10], index = addr[9:4], word offset = addr[3:2].
- Storage:
  - Per line: valid, dirty, tag, and 4×32-bit data words.
  - Data array is register-based with combinational read.
- Reset (async, rst=0):
  - All valid and dirty bits cleared; FSM to IDLE; word counter = 0.
  - Outputs: cpu_stall=0, cpu_dout=0, all ram_* = 0.
  - Counters = 0.
  - Any in-flight RAM transaction is abandoned.
- IDLE:
  - No request: cpu_stall=0.
  - Hit (valid && tag match):
    - cpu_stall=0; cpu_dout = word, combinational.
    - A store writes the word and sets dirty on the clk edge.
  - Miss:
    - cpu_stall=1 in the same cycle.
    - Go to WB if the victim is valid && dirty, else go to FILL.
- WB:
  - For k=0..3: ram_we=1, ram_addr = {victim_tag, index, k}, ram_dout = line word k.
  - Request held stable until ram_ack.
  - The next word is issued the cycle after the ack.
  - After the ack for k=3: go to FILL.
- FILL:
  - For k=0..3: ram_ren=1, ram_addr = {cpu_tag, index, k}, held until ram_ack.
  - On ack, ram_din is written into word k.
  - After k=3: tag updated, valid=1, dirty=0, go to RESP.
- RESP (one cycle):
  - cpu_stall=0 and the access completes as a hit.
  - Load returns cpu_dout; store writes the word and sets dirty.
  - Then IDLE.
- Latency:
  - Hit: 0 stall cycles.
  - Clean miss: 4 acks + 1 cycle.
  - Dirty miss: 8 acks + 1 cycle.
- Request stability: cpu_addr, cpu_din and cpu_ren/cpu_wen must stay stable while cpu_stall=1; violation is undefined.
- ram_ren and ram_we are never high together; ram_cs = ram_ren | ram_we.
- An ack arriving in IDLE or RESP is ignored.
- Word counter wraps 3→0 on each phase exit.

Optional Feature:
- Macro: DCACHE_STAT_EN.
- With the macro:
  - 32-bit hit_cnt and miss_cnt outputs are present.
  - hit_cnt increments on each IDLE hit; miss_cnt increments on each IDLE→WB/FILL transition.
  - RESP is not counted; counters saturate at 0xFFFFFFFF; reset to 0.
- Without the macro: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, WB=2'd1, FILL=2'd2, RESP=2'd3.
  - Address field position constants.
- One natural sub-module, dcache_line_array: valid/dirty/tag/data storage with combinational read port and one write port, used for both word write and refill write.
- The FSM stays in dcache_wb.

Test Plan:
- Cold load: cpu_addr=0x00000040, ram_ack after 2 cycles each, RAM word 0x10=0xA5A5A5A5.
  - Expect: 4 reads at ram_addr 0x10..0x13, then cpu_dout=0xA5A5A5A5 in RESP.
  - Expect: a repeat load hits with cpu_stall=0.
- Store hit then conflict load:
  - Store 0xDEADBEEF to 0x44 (hit after the prior fill), then load 0x440 (same index, tag differs).
  - Expect: 4 writes to 0x10..0x13 with word 0x11=0xDEADBEEF, then 4 reads 0x110..0x113.
- Simultaneous cpu_ren=cpu_wen=1: treated as a store; dirty set; a subsequent load returns the stored data.
- Async reset asserted mid-FILL (after 2 acks):
  - Expect: ram_ren drops immediately and cpu_stall=0.
  - Expect: the same address misses again after release.
- Slow RAM (ack after 10 cycles):
  - Expect: ram_addr, ram_ren and ram_dout held stable for all 10 cycles.
  - Expect: a stray ack in IDLE causes no state change.
- DCACHE_STAT_EN: sequence of hit, miss, hit, hit, miss → hit_cnt=3, miss_cnt=2.
